split_join_ctrl: RTL and testbench
==================================

Name: split_join_ctrl

Overview:
Per-core divergence controller that sits directly upstream of the per-warp IPDOM stack bank. It accepts split/join requests from the warp-control path and computes thread masks. It drives push/pop of the selected warp's stack, reading the stack top on join. It returns a registered mask/PC update to the scheduler over a valid/ready handshake.

Parameters:
NUM_WARPS, 4, number of warps; WIDW = max(1, clog2(NUM_WARPS))
NUM_THREADS, 4, threads per warp (mask width T)
PC_W, 32, PC width
Stack entry width STK_W = 1 + T + PC_W, layout {jump, tmask, pc}

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_wid  in  WIDW  warp id
req_is_join  in  1  1 = join, 0 = split
req_tmask  in  T  current warp thread mask
req_taken  in  T  per-thread branch predicate (split only)
req_else_pc  in  PC_W  not-taken target (split only)
rsp_valid  out  1  response valid
rsp_ready  in  1  scheduler accepts response
rsp_wid  out  WIDW  warp id
rsp_tmask  out  T  new thread mask
rsp_pc_valid  out  1  PC redirect required
rsp_pc  out  PC_W  redirect target
rsp_diverged  out  1  split pushed a stack entry
stk_wid  out  WIDW  stack bank select (= req_wid)
stk_push  out  1  push to stack stk_wid
stk_pop  out  1  pop from stack stk_wid
stk_q1  out  STK_W  entry popped second (restore)
stk_q2  out  STK_W  entry popped first (else path)
stk_d  in  STK_W  combinational top of stack stk_wid
stk_empty  in  1  stack stk_wid empty
stk_full  in  1  stack stk_wid full
err_overflow  out  NUM_WARPS  sticky: divergent split on full stack
err_underflow  out  NUM_WARPS  sticky: join on empty stack

Behaviour:
- req_ready = ~rsp_valid | rsp_ready. The block has one response register and accepts at most one request per cycle. Latency: response is visible 1 cycle after accept.
- stk_push and stk_pop are combinational in the accept cycle and are never asserted together. Both are forced to 0 while reset is high.
- Split: taken = req_tmask & req_taken; ntaken = req_tmask & ~req_taken.
  - taken == 0: rsp_tmask = req_tmask, rsp_pc_valid = 1, rsp_pc = req_else_pc, no push.
  - ntaken == 0: rsp_tmask = req_tmask, rsp_pc_valid = 0, no push.
  - Otherwise divergent, with stk_full = 0: stk_push = 1, stk_q2 = {1, ntaken, req_else_pc}, stk_q1 = {0, req_tmask, 0}; rsp_tmask = taken, rsp_pc_valid = 0, rsp_diverged = 1.
  - Divergent with stk_full = 1: no push; set err_overflow[wid]; rsp_tmask = req_tmask, rsp_diverged = 0.
- Join:
  - stk_empty = 0: stk_pop = 1; {rsp_pc_valid, rsp_tmask, rsp_pc} = stk_d sampled in the accept cycle.
  - stk_empty = 1: no pop; set err_underflow[wid]; rsp_tmask = req_tmask, rsp_pc_valid = 0.
- Stack contract: the first join after a split presents q2, the second presents q1.
- rsp_* fields are held stable while rsp_valid & ~rsp_ready.
- Reset (any cycle, including with a response pending): rsp_valid = 0. rsp_wid, rsp_tmask, rsp_pc, rsp_pc_valid and rsp_diverged reset to 0. err_* reset to 0. Any pending response is dropped.
- Error bits are sticky until reset.

Optional Feature:
SPLIT_JOIN_PERF_EN: when defined, the block adds the following outputs:
- perf_splits_div: 32-bit count of divergent pushes.
- perf_splits_uni: 32-bit count of uniform splits, including overflow-demoted splits.
- perf_joins: 32-bit count of successful pops.
Each counter increments on accept, wraps modulo 2^32 and resets to 0. When the macro is undefined, these ports and the counters are absent.

Test Plan:
1. Split, wid=1, tmask=4'b1111, taken=4'b0011, else_pc=0x100, stack not full -> stk_push=1, stk_q2={1,4'b1100,0x100}, stk_q1={0,4'b1111,0}; next cycle rsp_tmask=4'b0011, rsp_diverged=1, rsp_pc_valid=0.
2. Two joins on wid=1 with the stack returning q2 then q1 -> first response tmask=4'b1100, pc_valid=1, pc=0x100; second response tmask=4'b1111, pc_valid=0; two stk_pop pulses.
3. Uniform splits: taken=4'b0000, else_pc=0x200 -> pc_valid=1, pc=0x200, no push; then taken=4'b1111 -> pc_valid=0, tmask unchanged, no push.
4. Divergent split with stk_full=1 on wid=2 -> no push, err_overflow=4'b0100, rsp_tmask=req_tmask. Then join with stk_empty=1 on wid=3 -> no pop, err_underflow=4'b1000.
5. Backpressure: hold rsp_ready=0 with a response pending -> req_ready=0, no stack activity, rsp fields stable. Raise rsp_ready -> the queued request is accepted in that same cycle.
6. Assert reset while rsp_valid=1 and errors are set -> next cycle rsp_valid=0, err_*=0, stk_push/stk_pop=0 during reset. With SPLIT_JOIN_PERF_EN defined, all counters read 0.

Source files
------------

// File: rtl/split_join_ctrl.sv
// split_join_ctrl: per-core divergence controller that turns warp split/join
// requests into IPDOM stack push/pop and a registered mask/PC response.
// Ports:
//   clk, reset (sync, active-high)
//   req_*  : split/join request in (valid/ready)
//   rsp_*  : registered mask/PC update out (valid/ready)
//   stk_*  : push/pop/select to the per-warp stack bank, stk_d top-of-stack in
//   err_*  : sticky per-warp overflow/underflow flags
//   perf_* : event counters, present only with `define SPLIT_JOIN_PERF_EN
module split_join_ctrl #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_W        = 32,
  localparam int WIDW  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int T     = NUM_THREADS,
  localparam int STK_W = 1 + T + PC_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDW-1:0]      req_wid,
  input  logic                 req_is_join,
  input  logic [T-1:0]         req_tmask,
  input  logic [T-1:0]         req_taken,
  input  logic [PC_W-1:0]      req_else_pc,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDW-1:0]      rsp_wid,
  output logic [T-1:0]         rsp_tmask,
  output logic                 rsp_pc_valid,
  output logic [PC_W-1:0]      rsp_pc,
  output logic                 rsp_diverged,
  output logic [WIDW-1:0]      stk_wid,
  output logic                 stk_push,
  output logic                 stk_pop,
  output logic [STK_W-1:0]     stk_q1,
  output logic [STK_W-1:0]     stk_q2,
  input  logic [STK_W-1:0]     stk_d,
  input  logic                 stk_empty,
  input  logic                 stk_full,
`ifdef SPLIT_JOIN_PERF_EN
  output logic [31:0]          perf_splits_div,
  output logic [31:0]          perf_splits_uni,
  output logic [31:0]          perf_joins,
`endif
  output logic [NUM_WARPS-1:0] err_overflow,
  output logic [NUM_WARPS-1:0] err_underflow
);

  logic          accept;
  logic [T-1:0]  taken;
  logic [T-1:0]  ntaken;
  logic          any_t;
  logic          any_n;

  // one-hot request class
  logic c_pop;
  logic c_unf;
  logic c_none;
  logic c_all;
  logic c_div;
  logic c_ovf;

  logic [T-1:0]    n_tmask;
  logic            n_pcv;
  logic [PC_W-1:0] n_pc;
  logic            n_div;

  assign req_ready = ~rsp_valid | rsp_ready;
  assign accept    = req_valid & req_ready;

  assign taken  = req_tmask & req_taken;
  assign ntaken = req_tmask & ~req_taken;
  assign any_t  = |taken;
  assign any_n  = |ntaken;

  assign c_pop  = req_is_join & ~stk_empty;
  assign c_unf  = req_is_join & stk_empty;
  assign c_none = ~req_is_join & ~any_t;
  assign c_all  = ~req_is_join & any_t & ~any_n;
  assign c_div  = ~req_is_join & any_t & any_n & ~stk_full;
  assign c_ovf  = ~req_is_join & any_t & any_n & stk_full;

  assign stk_wid  = req_wid;
  assign stk_push = accept & c_div & ~reset;
  assign stk_pop  = accept & c_pop & ~reset;

  // else-path entry is popped first, reconvergence entry second
  assign stk_q2 = {1'b1, ntaken, req_else_pc};
  assign stk_q1 = {1'b0, req_tmask, {PC_W{1'b0}}};

  always_comb begin
    n_tmask = req_tmask;
    n_pcv   = 1'b0;
    n_pc    = '0;
    n_div   = 1'b0;
    unique case (1'b1)
      c_pop: begin
        {n_pcv, n_tmask, n_pc} = stk_d;
      end
      c_none: begin
        n_pcv = 1'b1;
        n_pc  = req_else_pc;
      end
      c_div: begin
        n_tmask = taken;
        n_div   = 1'b1;
      end
      // uniform-taken, overflow and underflow keep the incoming mask
      default: begin
        n_tmask = req_tmask;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid     <= 1'b0;
      rsp_wid       <= '0;
      rsp_tmask     <= '0;
      rsp_pc_valid  <= 1'b0;
      rsp_pc        <= '0;
      rsp_diverged  <= 1'b0;
      err_overflow  <= '0;
      err_underflow <= '0;
    end else begin
      if (accept) begin
        rsp_valid    <= 1'b1;
        rsp_wid      <= req_wid;
        rsp_tmask    <= n_tmask;
        rsp_pc_valid <= n_pcv;
        rsp_pc       <= n_pc;
        rsp_diverged <= n_div;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (accept && c_ovf)
        err_overflow[req_wid] <= 1'b1;
      if (accept && c_unf)
        err_underflow[req_wid] <= 1'b1;
    end
  end

`ifdef SPLIT_JOIN_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_splits_div <= '0;
      perf_splits_uni <= '0;
      perf_joins      <= '0;
    end else if (accept) begin
      if (c_div)
        perf_splits_div <= perf_splits_div + 32'd1;
      // a split demoted by overflow behaves as uniform
      if (c_none || c_all || c_ovf)
        perf_splits_uni <= perf_splits_uni + 32'd1;
      if (c_pop)
        perf_joins <= perf_joins + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_split_join_ctrl.sv
// tb_split_join_ctrl: directed scoreboard bench for split_join_ctrl.
// Driver queues expected responses; a negedge monitor pops and compares.
module tb_split_join_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_wid;
  logic        req_is_join;
  logic [3:0]  req_tmask;
  logic [3:0]  req_taken;
  logic [31:0] req_else_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_wid;
  logic [3:0]  rsp_tmask;
  logic        rsp_pc_valid;
  logic [31:0] rsp_pc;
  logic        rsp_diverged;
  logic [1:0]  stk_wid;
  logic        stk_push;
  logic        stk_pop;
  logic [36:0] stk_q1;
  logic [36:0] stk_q2;
  logic [36:0] stk_d;
  logic        stk_empty;
  logic        stk_full;
  logic [3:0]  err_overflow;
  logic [3:0]  err_underflow;
`ifdef SPLIT_JOIN_PERF_EN
  logic [31:0] perf_splits_div;
  logic [31:0] perf_splits_uni;
  logic [31:0] perf_joins;
`endif

  split_join_ctrl dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wid(req_wid),
    .req_is_join(req_is_join),
    .req_tmask(req_tmask),
    .req_taken(req_taken),
    .req_else_pc(req_else_pc),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_wid(rsp_wid),
    .rsp_tmask(rsp_tmask),
    .rsp_pc_valid(rsp_pc_valid),
    .rsp_pc(rsp_pc),
    .rsp_diverged(rsp_diverged),
    .stk_wid(stk_wid),
    .stk_push(stk_push),
    .stk_pop(stk_pop),
    .stk_q1(stk_q1),
    .stk_q2(stk_q2),
    .stk_d(stk_d),
    .stk_empty(stk_empty),
    .stk_full(stk_full),
`ifdef SPLIT_JOIN_PERF_EN
    .perf_splits_div(perf_splits_div),
    .perf_splits_uni(perf_splits_uni),
    .perf_joins(perf_joins),
`endif
    .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wid;
    logic [3:0]  tmask;
    logic        pcv;
    logic [31:0] pc;
    logic        div;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input logic [1:0] w, input logic [3:0] tm,
                              input logic pv, input logic [31:0] pc,
                              input logic dv);
    exp_t e;
    e.wid = w; e.tmask = tm; e.pcv = pv; e.pc = pc; e.div = dv;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // monitor: a response is consumed at the next posedge when valid & ready
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got wid=%0d tmask=%h want none",
                 rsp_wid, rsp_tmask);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_wid", 64'(rsp_wid), 64'(e.wid));
        chk("rsp_tmask", 64'(rsp_tmask), 64'(e.tmask));
        chk("rsp_pc_valid", 64'(rsp_pc_valid), 64'(e.pcv));
        if (e.pcv)
          chk("rsp_pc", 64'(rsp_pc), 64'(e.pc));
        chk("rsp_diverged", 64'(rsp_diverged), 64'(e.div));
      end
    end
  end

  // called just after a posedge; returns just after the accepting posedge
  task automatic issue(input logic [1:0] w, input logic j,
                       input logic [3:0] tm, input logic [3:0] tk,
                       input logic [31:0] epc, input exp_t e,
                       input logic pe, input logic po,
                       input logic [36:0] q1e, input logic [36:0] q2e);
    int n;
    req_wid     = w;
    req_is_join = j;
    req_tmask   = tm;
    req_taken   = tk;
    req_else_pc = epc;
    req_valid   = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got req_ready=0 want 1");
    end else begin
      chk("stk_push", 64'(stk_push), 64'(pe));
      chk("stk_pop", 64'(stk_pop), 64'(po));
      chk("stk_wid", 64'(stk_wid), 64'(w));
      if (pe) begin
        chk("stk_q1", 64'(stk_q1), 64'(q1e));
        chk("stk_q2", 64'(stk_q2), 64'(q2e));
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_wid     = '0;
    req_is_join = 1'b0;
    req_tmask   = '0;
    req_taken   = '0;
    req_else_pc = '0;
    rsp_ready   = 1'b1;
    stk_d       = '0;
    stk_empty   = 1'b1;
    stk_full    = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_err_ovf", 64'(err_overflow), 64'd0);
    chk("reset_err_unf", 64'(err_underflow), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;

    // divergent split on wid 1
    issue(2'd1, 1'b0, 4'b1111, 4'b0011, 32'h100,
          mk(2'd1, 4'b0011, 1'b0, 32'h0, 1'b1), 1'b1, 1'b0,
          {1'b0, 4'b1111, 32'h0}, {1'b1, 4'b1100, 32'h100});

    // two joins: else path first, then reconvergence
    stk_empty = 1'b0;
    stk_d = {1'b1, 4'b1100, 32'h100};
    issue(2'd1, 1'b1, 4'b0011, 4'b0000, 32'h0,
          mk(2'd1, 4'b1100, 1'b1, 32'h100, 1'b0), 1'b0, 1'b1, '0, '0);
    stk_d = {1'b0, 4'b1111, 32'h0};
    issue(2'd1, 1'b1, 4'b1100, 4'b0000, 32'h0,
          mk(2'd1, 4'b1111, 1'b0, 32'h0, 1'b0), 1'b0, 1'b1, '0, '0);
    stk_empty = 1'b1;

    // uniform splits
    issue(2'd0, 1'b0, 4'b1111, 4'b0000, 32'h200,
          mk(2'd0, 4'b1111, 1'b1, 32'h200, 1'b0), 1'b0, 1'b0, '0, '0);
    issue(2'd0, 1'b0, 4'b1111, 4'b1111, 32'h204,
          mk(2'd0, 4'b1111, 1'b0, 32'h0, 1'b0), 1'b0, 1'b0, '0, '0);
    // taken bits only on inactive lanes: nobody takes the branch
    issue(2'd0, 1'b0, 4'b0101, 4'b1010, 32'h208,
          mk(2'd0, 4'b0101, 1'b1, 32'h208, 1'b0), 1'b0, 1'b0, '0, '0);

    // overflow then underflow
    stk_full = 1'b1;
    issue(2'd2, 1'b0, 4'b1111, 4'b0011, 32'h300,
          mk(2'd2, 4'b1111, 1'b0, 32'h0, 1'b0), 1'b0, 1'b0, '0, '0);
    chk("err_overflow", 64'(err_overflow), 64'b0100);
    stk_full = 1'b0;
    stk_empty = 1'b1;
    issue(2'd3, 1'b1, 4'b0110, 4'b0000, 32'h0,
          mk(2'd3, 4'b0110, 1'b0, 32'h0, 1'b0), 1'b0, 1'b0, '0, '0);
    chk("err_underflow", 64'(err_underflow), 64'b1000);
    chk("err_overflow_sticky", 64'(err_overflow), 64'b0100);
    drain();

    // backpressure
    rsp_ready = 1'b0;
    issue(2'd0, 1'b0, 4'b1111, 4'b0000, 32'h300,
          mk(2'd0, 4'b1111, 1'b1, 32'h300, 1'b0), 1'b0, 1'b0, '0, '0);
    req_wid     = 2'd1;
    req_is_join = 1'b0;
    req_tmask   = 4'b1111;
    req_taken   = 4'b0101;
    req_else_pc = 32'h400;
    req_valid   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_stk_push", 64'(stk_push), 64'd0);
      chk("bp_stk_pop", 64'(stk_pop), 64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_tmask", 64'(rsp_tmask), 64'hF);
      chk("bp_rsp_pc", 64'(rsp_pc), 64'h300);
      chk("bp_rsp_pc_valid", 64'(rsp_pc_valid), 64'd1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(req_ready), 64'd1);
    chk("bp_release_push", 64'(stk_push), 64'd1);
    chk("bp_release_q2", 64'(stk_q2), 64'({1'b1, 4'b1010, 32'h400}));
    sb.push_back(mk(2'd1, 4'b0101, 1'b0, 32'h0, 1'b1));
    @(posedge clk);
    #1 req_valid = 1'b0;
    drain();

`ifdef SPLIT_JOIN_PERF_EN
    chk("perf_div", 64'(perf_splits_div), 64'd2);
    chk("perf_uni", 64'(perf_splits_uni), 64'd5);
    chk("perf_joins", 64'(perf_joins), 64'd2);
`endif

    // reset with a pending response and sticky errors
    rsp_ready = 1'b0;
    issue(2'd0, 1'b0, 4'b1111, 4'b1111, 32'h0,
          mk(2'd0, 4'b1111, 1'b0, 32'h0, 1'b0), 1'b0, 1'b0, '0, '0);
    chk("pre_reset_rsp_valid", 64'(rsp_valid), 64'd1);
    reset       = 1'b1;
    rsp_ready   = 1'b1;
    stk_full    = 1'b0;
    req_wid     = 2'd2;
    req_is_join = 1'b0;
    req_tmask   = 4'b1111;
    req_taken   = 4'b0011;
    req_valid   = 1'b1;
    @(negedge clk);
    chk("rst_stk_push", 64'(stk_push), 64'd0);
    @(posedge clk);
    #1;
    req_is_join = 1'b1;
    stk_empty   = 1'b0;
    @(negedge clk);
    chk("rst_stk_pop", 64'(stk_pop), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_err_ovf", 64'(err_overflow), 64'd0);
    chk("rst_err_unf", 64'(err_underflow), 64'd0);
    chk("rst_rsp_tmask", 64'(rsp_tmask), 64'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
`ifdef SPLIT_JOIN_PERF_EN
    chk("rst_perf_div", 64'(perf_splits_div), 64'd0);
    chk("rst_perf_uni", 64'(perf_splits_uni), 64'd0);
    chk("rst_perf_joins", 64'(perf_joins), 64'd0);
`endif
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
